// File: rtl/tile_ram_arbiter_pkg.sv
// Shared constants and enums for the tile RAM arbiter.
// Clear-on-reset sweep is enabled by TILE_RAM_CLEAR_ON_RESET_EN.
package tile_ram_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam logic [7:0] CLEAR_VALUE = 8'h00;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_VID,
    SRC_C0,
    SRC_C1
  } src_e;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;
endpackage

// File: rtl/tile_ram_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter with enable.
// rr_last_q holds the last granted client (0 = c0, 1 = c1).
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  logic rr_last_q, rr_last_d;

  always_comb begin
    gnt_o     = 2'b00;
    rr_last_d = rr_last_q;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = rr_last_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
      if (gnt_o[1]) rr_last_d = 1'b1;
      else if (gnt_o[0]) rr_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr_last_q <= 1'b1;
    else rr_last_q <= rr_last_d;
  end
endmodule

// File: rtl/tile_ram_arbiter.sv
// Tile RAM arbiter: video priority, two round-robin clients.
// Optional clear sweep after reset: TILE_RAM_CLEAR_ON_RESET_EN.
module tile_ram_arbiter #(
  parameter int ADDR_W = tile_ram_pkg::ADDR_W,
  parameter int DATA_W = tile_ram_pkg::DATA_W,
  parameter logic [DATA_W-1:0] CLEAR_VALUE =
    tile_ram_pkg::CLEAR_VALUE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_gnt,
  output logic              c0_rvalid,
  output logic [DATA_W-1:0] c0_rdata,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_gnt,
  output logic              c1_rvalid,
  output logic [DATA_W-1:0] c1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              ready
);
  import tile_ram_pkg::*;

  logic              clr_act;
  logic [ADDR_W-1:0] clr_addr;

`ifdef TILE_RAM_CLEAR_ON_RESET_EN
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Video takes the cycle; the sweep just pauses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_act = 1'b0;
    if (state_q == ST_CLEAR && !vid_req && !reset) begin
      clr_act = 1'b1;
      cnt_d   = cnt_q + 1'b1;
      if (&cnt_q) state_d = ST_RUN;
    end
  end

  assign clr_addr = cnt_q;
  assign ready    = (state_q == ST_RUN);
`else
  assign clr_act  = 1'b0;
  assign clr_addr = '0;
  assign ready    = 1'b1;
`endif

  logic [1:0]        gnt;
  src_e              tag_q, tag_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] vid_q, c0_q, c1_q;

  rr_arb2 u_rr (
    .clk   (clk),
    .reset (reset),
    .en_i  (ready & ~vid_req & ~reset),
    .req_i ({c1_req, c0_req}),
    .gnt_o (gnt)
  );

  assign c0_gnt = gnt[0];
  assign c1_gnt = gnt[1];

  always_comb begin
    ram_addr = addr_q;
    ram_din  = din_q;
    ram_we   = 1'b0;
    tag_d    = SRC_NONE;
    unique case (1'b1)
      vid_req: begin
        ram_addr = vid_addr;
        tag_d    = SRC_VID;
      end
      gnt[0]: begin
        ram_addr = c0_addr;
        ram_din  = c0_wdata;
        ram_we   = c0_we;
        tag_d    = c0_we ? SRC_NONE : SRC_C0;
      end
      gnt[1]: begin
        ram_addr = c1_addr;
        ram_din  = c1_wdata;
        ram_we   = c1_we;
        tag_d    = c1_we ? SRC_NONE : SRC_C1;
      end
      clr_act: begin
        ram_addr = clr_addr;
        ram_din  = CLEAR_VALUE;
        ram_we   = 1'b1;
      end
      default: ;
    endcase
  end

  // Returns are masked while reset is high so a pending read dies.
  assign vid_rvalid = (tag_q == SRC_VID) && !reset;
  assign c0_rvalid  = (tag_q == SRC_C0) && !reset;
  assign c1_rvalid  = (tag_q == SRC_C1) && !reset;

  assign vid_rdata = vid_rvalid ? ram_dout : vid_q;
  assign c0_rdata  = c0_rvalid ? ram_dout : c0_q;
  assign c1_rdata  = c1_rvalid ? ram_dout : c1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q  <= SRC_NONE;
      addr_q <= '0;
      din_q  <= '0;
      vid_q  <= '0;
      c0_q   <= '0;
      c1_q   <= '0;
    end else begin
      tag_q  <= tag_d;
      addr_q <= ram_addr;
      din_q  <= ram_din;
      vid_q  <= vid_rdata;
      c0_q   <= c0_rdata;
      c1_q   <= c1_rdata;
    end
  end
endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Directed self-checking bench for tile_ram_arbiter.
// Includes the clear sweep when TILE_RAM_CLEAR_ON_RESET_EN is set.
module tb_tile_ram_arbiter;
  logic       clk;
  logic       reset;
  logic       vid_req;
  logic [9:0] vid_addr;
  logic       vid_rvalid;
  logic [7:0] vid_rdata;
  logic       c0_req, c0_we, c0_gnt, c0_rvalid;
  logic [9:0] c0_addr;
  logic [7:0] c0_wdata, c0_rdata;
  logic       c1_req, c1_we, c1_gnt, c1_rvalid;
  logic [9:0] c1_addr;
  logic [7:0] c1_wdata, c1_rdata;
  logic [9:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic       ram_we, ready;

  logic [7:0] mem [0:1023];
  logic       pre_we;
  logic [9:0] pre_addr;

  int checks;
  int failures;
  int n;

  tile_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr),
    .c0_wdata(c0_wdata), .c0_gnt(c0_gnt),
    .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr),
    .c1_wdata(c1_wdata), .c1_gnt(c1_gnt),
    .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_dout(ram_dout),
    .ready(ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= 8'hFF;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    clk = 0; reset = 1; pre_we = 0; pre_addr = '0;
    vid_req = 0; vid_addr = '0;
    c0_req = 0; c0_we = 0; c0_addr = '0; c0_wdata = '0;
    c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0;

    @(negedge clk);
    c0_req = 1; c0_we = 1; c1_req = 1; c1_we = 1;
    #1;
    chk("rst_c0_gnt", c0_gnt, 0);
    chk("rst_c1_gnt", c1_gnt, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_rv", {vid_rvalid, c0_rvalid, c1_rvalid}, 0);
`ifdef TILE_RAM_CLEAR_ON_RESET_EN
    chk("rst_ready", ready, 0);
`else
    chk("rst_ready", ready, 1);
`endif

    @(negedge clk);
    reset = 0; c0_req = 0; c1_req = 0;
    #1;
    n = 0;
    while (!ready && n < 3000) begin
      @(negedge clk); #1; n++;
    end
    chk("ready_up", ready, 1);

    @(negedge clk);
    c0_req = 1; c0_we = 1; c0_addr = 10'h021; c0_wdata = 8'h05;
    c1_req = 1; c1_we = 1; c1_addr = 10'h100; c1_wdata = 8'h77;
    #1;
    chk("rr0_c0_gnt", c0_gnt, 1);
    chk("rr0_c1_gnt", c1_gnt, 0);
    chk("rr0_addr", ram_addr, 10'h021);
    chk("rr0_din", ram_din, 8'h05);
    chk("rr0_we", ram_we, 1);
    @(negedge clk); #1;
    chk("rr1_c1_gnt", c1_gnt, 1);
    chk("rr1_c0_gnt", c0_gnt, 0);
    chk("rr1_addr", ram_addr, 10'h100);
    chk("rr1_din", ram_din, 8'h77);
    @(negedge clk); #1;
    chk("rr2_c0_gnt", c0_gnt, 1);
    @(negedge clk); #1;
    chk("rr3_c1_gnt", c1_gnt, 1);

    @(negedge clk);
    c0_req = 0; c1_req = 0;
    #1;
    chk("idle_we", ram_we, 0);
    chk("idle_addr", ram_addr, 10'h100);
    chk("idle_gnt", {c0_gnt, c1_gnt}, 0);
    chk("idle_rv", {c0_rvalid, c1_rvalid}, 0);

    @(negedge clk);
    c0_req = 1; c0_we = 0; c0_addr = 10'h021;
    #1;
    chk("rd_gnt", c0_gnt, 1);
    chk("rd_we", ram_we, 0);
    chk("rd_addr", ram_addr, 10'h021);
    @(negedge clk);
    c0_req = 0;
    #1;
    chk("rd_rv", c0_rvalid, 1);
    chk("rd_data", c0_rdata, 8'h05);
    chk("rd_c1_rv", c1_rvalid, 0);
    @(negedge clk); #1;
    chk("rd_hold_rv", c0_rvalid, 0);
    chk("rd_hold", c0_rdata, 8'h05);

    @(negedge clk);
    vid_req = 1; vid_addr = 10'h100;
    c0_req = 1; c0_we = 0; c0_addr = 10'h021;
    #1;
    chk("v0_gnt", c0_gnt, 0);
    chk("v0_addr", ram_addr, 10'h100);
    chk("v0_we", ram_we, 0);
    @(negedge clk); #1;
    chk("v1_gnt", c0_gnt, 0);
    chk("v1_rv", vid_rvalid, 1);
    chk("v1_data", vid_rdata, 8'h77);
    @(negedge clk); #1;
    chk("v2_gnt", c0_gnt, 0);
    chk("v2_rv", vid_rvalid, 1);
    @(negedge clk);
    vid_req = 0;
    #1;
    chk("v3_gnt", c0_gnt, 1);
    chk("v3_rv", vid_rvalid, 1);
    chk("v3_addr", ram_addr, 10'h021);
    @(negedge clk);
    c0_req = 0;
    #1;
    chk("v4_c0_rv", c0_rvalid, 1);
    chk("v4_c0_data", c0_rdata, 8'h05);
    chk("v4_vid_rv", vid_rvalid, 0);
    chk("v4_vid_hold", vid_rdata, 8'h77);

    @(negedge clk);
    c1_req = 1; c1_we = 1; c1_addr = 10'h3FF; c1_wdata = 8'hA3;
    #1;
    chk("raw_w_gnt", c1_gnt, 1);
    chk("raw_w_we", ram_we, 1);
    @(negedge clk);
    c1_req = 0; c0_req = 1; c0_we = 0; c0_addr = 10'h3FF;
    #1;
    chk("raw_r_gnt", c0_gnt, 1);
    @(negedge clk);
    c0_req = 0;
    #1;
    chk("raw_rv", c0_rvalid, 1);
    chk("raw_data", c0_rdata, 8'hA3);

    @(negedge clk);
    c0_req = 1; c0_we = 0; c0_addr = 10'h021;
    c1_req = 1; c1_we = 0; c1_addr = 10'h100;
    #1;
    chk("tie_c1_gnt", c1_gnt, 1);
    chk("tie_c0_gnt", c0_gnt, 0);
    @(negedge clk);
    reset = 1;
    #1;
    chk("rstm_c1_rv", c1_rvalid, 0);
    chk("rstm_gnt", {c0_gnt, c1_gnt}, 0);
    chk("rstm_we", ram_we, 0);
    @(negedge clk);
    reset = 0; c0_req = 0; c1_req = 0;
    #1;
    chk("rstm_after_rv", c1_rvalid, 0);

`ifdef TILE_RAM_CLEAR_ON_RESET_EN
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      pre_we = 1; pre_addr = i[9:0];
    end
    @(negedge clk);
    pre_we = 0; reset = 0;
    #1;
    n = 0;
    while (!ready && n < 3000) begin
      n++;
      vid_req = (n == 500);
      vid_addr = 10'h000;
      @(negedge clk); #1;
    end
    vid_req = 0;
    chk("clr_cycles", n, 1025);
    @(negedge clk);
    c0_req = 1; c0_we = 0; c0_addr = 10'h000;
    #1;
    chk("clr_rd0_gnt", c0_gnt, 1);
    @(negedge clk);
    c0_addr = 10'h3FF;
    #1;
    chk("clr_rd0_data", c0_rdata, 8'h00);
    chk("clr_rd1_gnt", c0_gnt, 1);
    @(negedge clk);
    c0_req = 0;
    #1;
    chk("clr_rd1_data", c0_rdata, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
